mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller for the EX stage.
// Owns the HI/LO registers, models fixed MDU latency with a down-counter
// and raises busy so the hazard unit can stall dependent instructions.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;

    logic [63:0] mul_res;
    logic [63:0] div_res;
    logic [31:0] b_safe;

    // 64-bit product; operands are widened to 65 bits so one signed
    // multiplier covers both MULT and MULTU.
    function automatic logic [63:0] mul64(input logic is_signed,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [64:0] sa;
        logic signed [64:0] sb;
        logic signed [64:0] p;
        sa = is_signed ? $signed({{33{a[31]}}, a}) : $signed({33'b0, a});
        sb = is_signed ? $signed({{33{b[31]}}, b}) : $signed({33'b0, b});
        p  = sa * sb;
        return p[63:0];
    endfunction

    // Returns {remainder, quotient}. A 33-bit signed divide truncates toward
    // zero, keeps the dividend's sign on the remainder, and makes the
    // 0x80000000 / -1 overflow yield +2^31, whose low word is 0x80000000.
    function automatic logic [63:0] div64(input logic is_signed,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [32:0] sa;
        logic signed [32:0] sb;
        logic signed [32:0] q;
        logic signed [32:0] r;
        sa = is_signed ? $signed({a[31], a}) : $signed({1'b0, a});
        sb = is_signed ? $signed({b[31], b}) : $signed({1'b0, b});
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Result datapath from latched operands; divisor forced nonzero so the
    // divider never sees zero (the zero case never writes HI/LO anyway).
    always_comb begin
        b_safe  = (b_q == 32'd0) ? 32'd1 : b_q;
        mul_res = mul64(~op_q[0], a_q, b_q);
        div_res = div64(~op_q[0], a_q, b_safe);
    end

    // Next-state logic: command acceptance in IDLE, countdown and writeback in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            op_d    = MDUOp[1:0];
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = 4'(MULT_CYCLES);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = MDUOp[1:0];
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = 4'(DIV_CYCLES);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                    if (!op_q[1]) begin
                        {hi_d, lo_d} = mul_res;
                    end else if (b_q != 32'd0) begin
                        {hi_d, lo_d} = div_res;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and architectural HI/LO; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Latched operands are pure data and only matter while RUN is active.
    always_ff @(posedge clk) begin
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests;
    int fails;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .MDUOp(MDUOp),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, busy=%0b", busy);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests++; if (HI !== 32'd0) begin fails++; $display("FAIL reset_hi: got %08h want 00000000", HI); end
        tests++; if (LO !== 32'd0) begin fails++; $display("FAIL reset_lo: got %08h want 00000000", LO); end
    endtask

    task automatic test_mult();
        issue(3'd0, 32'hFFFFFFFF, 32'h00000002);
        tests++; if (HI !== 32'd0 || LO !== 32'd0) begin fails++; $display("FAIL mult_early_write: got %08h_%08h want 00000000_00000000", HI, LO); end
        for (int i = 0; i < MULT_N; i++) begin
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mult_busy[%0d]: got %0b want 1", i, busy); end
            tick();
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mult_done_busy: got %0b want 0", busy); end
        tests++; if (HI !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi: got %08h want ffffffff", HI); end
        tests++; if (LO !== 32'hFFFFFFFE) begin fails++; $display("FAIL mult_lo: got %08h want fffffffe", LO); end
    endtask

    task automatic test_multu();
        issue(3'd1, 32'hFFFFFFFF, 32'h00000002);
        for (int i = 0; i < MULT_N; i++) begin
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL multu_busy[%0d]: got %0b want 1", i, busy); end
            A = 32'h0000_0100 + i;
            B = 32'h1357_9BDF;
            tick();
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL multu_done_busy: got %0b want 0", busy); end
        tests++; if (HI !== 32'h00000001) begin fails++; $display("FAIL multu_hi: got %08h want 00000001", HI); end
        tests++; if (LO !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_lo: got %08h want fffffffe", LO); end
    endtask

    task automatic test_div();
        issue(3'd2, 32'hFFFFFFF9, 32'h00000002);
        for (int i = 0; i < DIV_N; i++) begin
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL div_busy[%0d]: got %0b want 1", i, busy); end
            tick();
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL div_done_busy: got %0b want 0", busy); end
        tests++; if (LO !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo: got %08h want fffffffd", LO); end
        tests++; if (HI !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi: got %08h want ffffffff", HI); end
    endtask

    task automatic test_div_overflow();
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        for (int i = 0; i < DIV_N; i++) tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL divovf_busy: got %0b want 0", busy); end
        tests++; if (LO !== 32'h80000000) begin fails++; $display("FAIL divovf_lo: got %08h want 80000000", LO); end
        tests++; if (HI !== 32'h00000000) begin fails++; $display("FAIL divovf_hi: got %08h want 00000000", HI); end
    endtask

    task automatic test_div_by_zero();
        issue(3'd4, 32'h00001234, 32'h0);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy: got %0b want 0", busy); end
        tests++; if (HI !== 32'h00001234) begin fails++; $display("FAIL mthi_hi: got %08h want 00001234", HI); end
        tests++; if (LO !== 32'h80000000) begin fails++; $display("FAIL mthi_lo_kept: got %08h want 80000000", LO); end
        issue(3'd5, 32'h00005678, 32'h0);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mtlo_busy: got %0b want 0", busy); end
        tests++; if (LO !== 32'h00005678) begin fails++; $display("FAIL mtlo_lo: got %08h want 00005678", LO); end
        tests++; if (HI !== 32'h00001234) begin fails++; $display("FAIL mtlo_hi_kept: got %08h want 00001234", HI); end
        issue(3'd3, 32'h00000007, 32'h00000000);
        for (int i = 0; i < DIV_N; i++) begin
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL divz_busy[%0d]: got %0b want 1", i, busy); end
            tick();
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL divz_done_busy: got %0b want 0", busy); end
        tests++; if (HI !== 32'h00001234) begin fails++; $display("FAIL divz_hi: got %08h want 00001234", HI); end
        tests++; if (LO !== 32'h00005678) begin fails++; $display("FAIL divz_lo: got %08h want 00005678", LO); end
    endtask

    task automatic test_reserved();
        issue(3'd6, 32'hAAAA5555, 32'h0);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rsv6_busy: got %0b want 0", busy); end
        issue(3'd7, 32'h5555AAAA, 32'h0);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rsv7_busy: got %0b want 0", busy); end
        tests++; if (HI !== 32'h00001234 || LO !== 32'h00005678) begin fails++; $display("FAIL rsv_hilo: got %08h_%08h want 00001234_00005678", HI, LO); end
    endtask

    task automatic test_reset_in_run();
        issue(3'd3, 32'd100, 32'd7);
        tick();
        tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rrun_busy_c3: got %0b want 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rrun_busy: got %0b want 0", busy); end
        tests++; if (HI !== 32'd0 || LO !== 32'd0) begin fails++; $display("FAIL rrun_hilo: got %08h_%08h want 00000000_00000000", HI, LO); end
        for (int i = 0; i < DIV_N + 2; i++) tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rrun_late_busy: got %0b want 0", busy); end
        tests++; if (HI !== 32'd0 || LO !== 32'd0) begin fails++; $display("FAIL rrun_late_write: got %08h_%08h want 00000000_00000000", HI, LO); end
    endtask

    task automatic test_start_while_busy();
        issue(3'd0, 32'd3, 32'd4);
        tick();
        start = 1'b1;
        MDUOp = 3'd0;
        A     = 32'd5;
        B     = 32'd6;
        tick();
        MDUOp = 3'd5;
        A     = 32'h0000DEAD;
        tick();
        start = 1'b0;
        tests++; if (LO !== 32'd0) begin fails++; $display("FAIL swb_mtlo_ignored: got %08h want 00000000", LO); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL swb_busy_c4: got %0b want 1", busy); end
        tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL swb_busy_c5: got %0b want 1", busy); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL swb_done_busy: got %0b want 0", busy); end
        tests++; if (HI !== 32'd0 || LO !== 32'd12) begin fails++; $display("FAIL swb_result: got %08h_%08h want 00000000_0000000c", HI, LO); end
    endtask

    task automatic test_back_to_back();
        issue(3'd1, 32'h00010000, 32'h00010000);
        for (int i = 0; i < MULT_N; i++) tick();
        tests++; if (busy !== 1'b0 || HI !== 32'd1 || LO !== 32'd0) begin fails++; $display("FAIL b2b_multu: got busy=%0b %08h_%08h want busy=0 00000001_00000000", busy, HI, LO); end
        issue(3'd3, 32'd100, 32'd7);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_divu_start: got %0b want 1", busy); end
        for (int i = 0; i < DIV_N - 1; i++) tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_divu_last: got %0b want 1", busy); end
        tick();
        tests++; if (busy !== 1'b0 || HI !== 32'd2 || LO !== 32'd14) begin fails++; $display("FAIL b2b_divu: got busy=%0b %08h_%08h want busy=0 00000002_0000000e", busy, HI, LO); end
        issue(3'd4, 32'h0000CAFE, 32'h0);
        tests++; if (busy !== 1'b0 || HI !== 32'h0000CAFE || LO !== 32'd14) begin fails++; $display("FAIL b2b_mthi: got busy=%0b %08h_%08h want busy=0 0000cafe_0000000e", busy, HI, LO); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        start = 1'b0;
        MDUOp = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_overflow();
        test_div_by_zero();
        test_reserved();
        test_reset_in_run();
        test_start_while_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
